// File: rtl/spi_pwm_pkg.sv
// Shared constants, register map and SPI command type for spi_pwm_ctrl.
// Imported by the SPI frame front end and the PWM register/output block.
package spi_pwm_pkg;

    localparam int         FRAME_BITS = 16;
    localparam logic [7:0] PWM_TOP    = 8'd254;

    localparam logic [6:0] ADDR_OUT_EN_LO = 7'h00;
    localparam logic [6:0] ADDR_OUT_EN_HI = 7'h01;
    localparam logic [6:0] ADDR_PWM_EN_LO = 7'h02;
    localparam logic [6:0] ADDR_PWM_EN_HI = 7'h03;
    localparam logic [6:0] ADDR_PRESCALE  = 7'h04;
    localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;

    // Decoded 16-bit frame: {rw, addr[6:0], data[7:0]}, MSB first on the wire.
    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } spi_cmd_t;

endpackage

// File: rtl/spi_frame_if.sv
// SPI mode-0 frame receiver/transmitter running entirely in the clk domain.
// Ports: sclk/copi/ncs raw pins in; cipo/cipo_oe out; rd_req/rd_addr/rd_data
// register read lookup; cmd_vld/cmd one-cycle strobe for a complete frame.
module spi_frame_if
    import spi_pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic       cipo_oe,
    output logic       rd_req,
    output logic [6:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       cmd_vld,
    output spi_cmd_t   cmd
);

    localparam logic [4:0] FULL_CNT = 5'(FRAME_BITS);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ncs_prev_q, ncs_prev_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [15:0]            rx_q, rx_d;
    logic [7:0]             tx_q, tx_d;
    logic                   cipo_q, cipo_d;
    logic                   cmd_vld_q, cmd_vld_d;
    spi_cmd_t               cmd_q, cmd_d;

    logic        sclk_s, copi_s, ncs_s;
    logic        sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    logic [15:0] rx_next;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};

        sclk_s = sclk_sync_q[SYNC_STAGES-1];
        copi_s = copi_sync_q[SYNC_STAGES-1];
        ncs_s  = ncs_sync_q[SYNC_STAGES-1];

        sclk_rise = sclk_s & ~sclk_prev_q;
        sclk_fall = ~sclk_s & sclk_prev_q;
        ncs_rise  = ncs_s & ~ncs_prev_q;
        ncs_fall  = ~ncs_s & ncs_prev_q;
        rx_next   = {rx_q[14:0], copi_s};

        sclk_prev_d = sclk_s;
        ncs_prev_d  = ncs_s;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        cipo_d      = cipo_q;
        cmd_vld_d   = 1'b0;
        cmd_d       = cmd_q;
        rd_req      = 1'b0;
        rd_addr     = rx_next[6:0];

        if (ncs_rise) begin
            // Only an exactly-complete frame is handed on; short ones vanish.
            cmd_vld_d = (bit_cnt_q == FULL_CNT);
            cmd_d     = rx_q;
            bit_cnt_d = '0;
            tx_d      = '0;
            cipo_d    = 1'b0;
        end else if (ncs_s) begin
            bit_cnt_d = '0;
            tx_d      = '0;
            cipo_d    = 1'b0;
        end else if (ncs_fall) begin
            bit_cnt_d = '0;
            rx_d      = '0;
            tx_d      = '0;
            cipo_d    = 1'b0;
        end else begin
            if (sclk_rise && bit_cnt_q < FULL_CNT) begin
                rx_d      = rx_next;
                bit_cnt_d = bit_cnt_q + 5'd1;
                // 8th bit completes {rw, addr}: fetch read data now.
                if (bit_cnt_q == 5'd7 && !rx_next[7]) begin
                    rd_req = 1'b1;
                    tx_d   = rd_data;
                end
            end
            if (sclk_fall) begin
                cipo_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            cipo_q      <= 1'b0;
            cmd_vld_q   <= 1'b0;
            cmd_q       <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ncs_prev_q  <= ncs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            cipo_q      <= cipo_d;
            cmd_vld_q   <= cmd_vld_d;
            cmd_q       <= cmd_d;
        end
    end

    assign cipo    = cipo_q;
    assign cipo_oe = ~ncs_s;
    assign cmd_vld = cmd_vld_q;
    assign cmd     = cmd_q;

endmodule

// File: rtl/spi_pwm_ctrl.sv
// Multi-channel PWM peripheral configured over SPI with read-back.
// Ports: clk/rst_n; sclk/copi/ncs SPI in; cipo/cipo_oe SPI out; pwm_out[NUM_CH].
module spi_pwm_ctrl
    import spi_pwm_pkg::*;
#(
    parameter int         NUM_CH       = 16,
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] PRESCALE_RST = 8'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic              cipo,
    output logic              cipo_oe,
    output logic [NUM_CH-1:0] pwm_out
);

    logic              rd_req;
    logic [6:0]        rd_addr;
    logic [7:0]        rd_data;
    logic              cmd_vld;
    spi_cmd_t          cmd;
    logic              wr;
    logic              tick;

    logic [NUM_CH-1:0]      out_en_q, out_en_d;
    logic [NUM_CH-1:0]      pwm_en_q, pwm_en_d;
    logic [7:0]             prescale_q, prescale_d;
    logic [7:0]             pcnt_q, pcnt_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [NUM_CH-1:0][7:0] duty_q, duty_d;
    logic [NUM_CH-1:0][7:0] active_q, active_d;
    logic [NUM_CH-1:0]      pwm_q, pwm_d;

    spi_frame_if #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_spi (
        .clk    (clk),
        .rst_n  (rst_n),
        .sclk   (sclk),
        .copi   (copi),
        .ncs    (ncs),
        .cipo   (cipo),
        .cipo_oe(cipo_oe),
        .rd_req (rd_req),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .cmd_vld(cmd_vld),
        .cmd    (cmd)
    );

    always_comb begin
        rd_data = '0;
        if (rd_req) begin
            if (rd_addr == ADDR_PRESCALE) rd_data = prescale_q;
            for (int k = 0; k < NUM_CH; k++) begin
                if (rd_addr == ADDR_OUT_EN_LO && k < 8) rd_data[3'(k)] = out_en_q[k];
                if (rd_addr == ADDR_OUT_EN_HI && k >= 8) rd_data[3'(k)] = out_en_q[k];
                if (rd_addr == ADDR_PWM_EN_LO && k < 8) rd_data[3'(k)] = pwm_en_q[k];
                if (rd_addr == ADDR_PWM_EN_HI && k >= 8) rd_data[3'(k)] = pwm_en_q[k];
                if (rd_addr == ADDR_DUTY_BASE + 7'(k)) rd_data = duty_q[k];
            end
        end
    end

    always_comb begin
        wr         = cmd_vld && cmd.rw;
        tick       = (pcnt_q == prescale_q);
        out_en_d   = out_en_q;
        pwm_en_d   = pwm_en_q;
        prescale_d = prescale_q;
        duty_d     = duty_q;
        active_d   = active_q;
        pcnt_d     = tick ? 8'd0 : pcnt_q + 8'd1;
        cnt_d      = cnt_q;

        if (tick) cnt_d = (cnt_q == PWM_TOP) ? 8'd0 : cnt_q + 8'd1;
        // Shadow copy uses pre-write duty, so a same-cycle commit waits a period.
        if (tick && cnt_q == PWM_TOP) active_d = duty_q;

        if (wr && cmd.addr == ADDR_PRESCALE) begin
            prescale_d = cmd.data;
            pcnt_d     = 8'd0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (wr && cmd.addr == ADDR_OUT_EN_LO && k < 8) out_en_d[k] = cmd.data[3'(k)];
            if (wr && cmd.addr == ADDR_OUT_EN_HI && k >= 8) out_en_d[k] = cmd.data[3'(k)];
            if (wr && cmd.addr == ADDR_PWM_EN_LO && k < 8) pwm_en_d[k] = cmd.data[3'(k)];
            if (wr && cmd.addr == ADDR_PWM_EN_HI && k >= 8) pwm_en_d[k] = cmd.data[3'(k)];
            if (wr && cmd.addr == ADDR_DUTY_BASE + 7'(k)) duty_d[k] = cmd.data;
        end

        for (int k = 0; k < NUM_CH; k++) begin
            if (!out_en_q[k])              pwm_d[k] = 1'b0;
            else if (!pwm_en_q[k])         pwm_d[k] = 1'b1;
            else if (active_q[k] == 8'hFF) pwm_d[k] = 1'b1;
            else                           pwm_d[k] = (cnt_q < active_q[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en_q   <= '0;
            pwm_en_q   <= '0;
            prescale_q <= PRESCALE_RST;
            pcnt_q     <= '0;
            cnt_q      <= '0;
            duty_q     <= '0;
            active_q   <= '0;
            pwm_q      <= '0;
        end else begin
            out_en_q   <= out_en_d;
            pwm_en_q   <= pwm_en_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            active_q   <= active_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_spi_pwm_ctrl.sv
// Self-checking bench for spi_pwm_ctrl: SPI register access, waveform
// duty/period, shadowed duty updates, aborted frames and mid-frame reset.
module tb_spi_pwm_ctrl;

    localparam int         NCH    = 4;
    localparam logic [7:0] PRST   = 8'h05;
    localparam int         HALF   = 8;
    localparam logic [15:0] CHMASK = 16'((32'd1 << NCH) - 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sclk = 1'b0;
    logic           copi = 1'b0;
    logic           ncs = 1'b1;
    logic           cipo;
    logic           cipo_oe;
    logic [NCH-1:0] pwm_out;

    int total = 0;
    int bad = 0;

    logic [15:0] m_out_en;
    logic [15:0] m_pwm_en;
    logic [7:0]  m_prescale;
    logic [7:0]  m_duty [16];

    int          hi_cnt [NCH];
    logic [7:0]  rd;
    int          gap;
    int          nbad;
    int          nruns;
    int          last_run;
    logic [7:0]  rv;

    always #5 clk = ~clk;

    spi_pwm_ctrl #(
        .NUM_CH      (NCH),
        .SYNC_STAGES (2),
        .PRESCALE_RST(PRST)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sclk   (sclk),
        .copi   (copi),
        .ncs    (ncs),
        .cipo   (cipo),
        .cipo_oe(cipo_oe),
        .pwm_out(pwm_out)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_out_en   = '0;
        m_pwm_en   = '0;
        m_prescale = PRST;
        for (int i = 0; i < 16; i++) m_duty[i] = '0;
    endtask

    task automatic m_write(input logic [6:0] a, input logic [7:0] d);
        case (a)
            7'h00:   m_out_en[7:0]  = d;
            7'h01:   m_out_en[15:8] = d;
            7'h02:   m_pwm_en[7:0]  = d;
            7'h03:   m_pwm_en[15:8] = d;
            7'h04:   m_prescale     = d;
            default: if (a >= 7'h10 && int'(a) < 16 + NCH) m_duty[a - 7'h10] = d;
        endcase
    endtask

    function automatic logic [7:0] m_read(input logic [6:0] a);
        logic [15:0] oe;
        logic [15:0] pe;
        oe = m_out_en & CHMASK;
        pe = m_pwm_en & CHMASK;
        case (a)
            7'h00:   return oe[7:0];
            7'h01:   return oe[15:8];
            7'h02:   return pe[7:0];
            7'h03:   return pe[15:8];
            7'h04:   return m_prescale;
            default: begin
                if (a >= 7'h10 && int'(a) < 16 + NCH) return m_duty[a - 7'h10];
                return 8'h00;
            end
        endcase
    endfunction

    function automatic int per();
        return 255 * (int'(m_prescale) + 1);
    endfunction

    // High clocks per full period, straight from the output rules.
    function automatic int exp_high(input int k);
        if (!m_out_en[k]) return 0;
        if (!m_pwm_en[k]) return per();
        if (m_duty[k] == 8'hFF) return per();
        return int'(m_duty[k]) * (int'(m_prescale) + 1);
    endfunction

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic s);
        copi = b;
        tick_n(HALF);
        s = cipo;
        sclk = 1'b1;
        tick_n(HALF);
        sclk = 1'b0;
    endtask

    task automatic spi_xfer(input logic [15:0] w, input int nbits,
                            output logic [7:0] r);
        logic s;
        r = '0;
        ncs = 1'b0;
        tick_n(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(w[15-i], s);
            if (i >= 8) r = {r[6:0], s};
        end
        tick_n(HALF);
        ncs = 1'b1;
        tick_n(HALF);
    endtask

    task automatic spi_wr(input logic [6:0] a, input logic [7:0] d);
        logic [7:0] r;
        spi_xfer({1'b1, a, d}, 16, r);
        m_write(a, d);
    endtask

    task automatic spi_rd(input logic [6:0] a, output logic [7:0] r);
        spi_xfer({1'b0, a, 8'h00}, 16, r);
    endtask

    task automatic measure(input int len);
        for (int k = 0; k < NCH; k++) hi_cnt[k] = 0;
        for (int t = 0; t < len; t++) begin
            tick_n(1);
            for (int k = 0; k < NCH; k++) if (pwm_out[k]) hi_cnt[k]++;
        end
    endtask

    task automatic check_all(input string tag);
        measure(per());
        for (int k = 0; k < NCH; k++)
            check($sformatf("%s_hi_ch%0d", tag, k), hi_cnt[k], exp_high(k));
    endtask

    task automatic edge_gap(input int ch, input int limit, output int g);
        int   seen;
        int   last;
        logic prev;
        seen = 0;
        last = 0;
        g = -1;
        prev = pwm_out[ch];
        for (int t = 0; t < limit && seen < 2; t++) begin
            tick_n(1);
            if (pwm_out[ch] && !prev) begin
                if (seen == 1) g = t - last;
                last = t;
                seen++;
            end
            prev = pwm_out[ch];
        end
    endtask

    // Lengths of high pulses that start and end inside the window.
    task automatic runs(input int ch, input int len, input int a, input int b,
                        output int nb, output int nr, output int lr);
        int   run;
        logic prev;
        logic cur;
        run = -1;
        nb = 0;
        nr = 0;
        lr = -1;
        prev = pwm_out[ch];
        for (int t = 0; t < len; t++) begin
            tick_n(1);
            cur = pwm_out[ch];
            if (cur && !prev) run = 1;
            else if (cur && run >= 0) run++;
            if (!cur && prev && run >= 0) begin
                nr++;
                lr = run;
                if (run != a && run != b) nb++;
            end
            prev = cur;
        end
    endtask

    initial begin
        m_reset();
        tick_n(3);
        check("reset_pwm", pwm_out, '0);
        check("reset_cipo", cipo, 1'b0);
        check("reset_cipo_oe", cipo_oe, 1'b0);
        rst_n = 1'b1;
        tick_n(4);

        spi_rd(7'h04, rd);
        check("rd_prescale_rst", rd, m_read(7'h04));
        spi_rd(7'h10, rd);
        check("rd_duty0_rst", rd, 8'h00);

        spi_wr(7'h00, 8'hFF);
        spi_wr(7'h02, 8'hFF);
        spi_wr(7'h10, 8'h80);
        spi_wr(7'h04, 8'h00);
        spi_rd(7'h10, rd);
        check("rd_duty0_80", rd, 8'h80);
        spi_rd(7'h00, rd);
        check("rd_out_en_lo", rd, m_read(7'h00));
        tick_n(per() + 10);
        check_all("basic");
        check("basic_ch0_128", hi_cnt[0], 128);
        edge_gap(0, 3 * per(), gap);
        check("basic_period", gap, 255);

        spi_wr(7'h13, 8'hC0);
        tick_n(2 * per());
        fork
            spi_wr(7'h13, 8'h40);
            runs(3, 4 * per(), 192, 64, nbad, nruns, last_run);
        join
        check("shadow_no_glitch", nbad, 0);
        check("shadow_last_run", last_run, 64);
        check_all("shadow");

        spi_xfer({1'b1, 7'h10, 8'h11}, 10, rd);
        for (int a = 0; a < 5; a++) begin
            spi_rd(7'(a), rd);
            check($sformatf("abort_rd_%0h", a), rd, m_read(7'(a)));
        end
        for (int a = 16; a < 16 + NCH; a++) begin
            spi_rd(7'(a), rd);
            check($sformatf("abort_rd_%0h", a), rd, m_read(7'(a)));
        end
        spi_wr(7'h10, 8'h11);
        spi_rd(7'h10, rd);
        check("after_abort_commit", rd, 8'h11);

        spi_wr(7'h11, 8'hFF);
        spi_wr(7'h02, 8'hFB);
        spi_wr(7'h00, 8'hF7);
        tick_n(per() + 10);
        check_all("modes");

        spi_wr(7'h00, 8'h0F);
        spi_wr(7'h02, 8'h0F);
        spi_wr(7'h10, 8'h01);
        spi_wr(7'h04, 8'h03);
        tick_n(per() + 10);
        check_all("ps3");
        check("ps3_ch0_4", hi_cnt[0], 4);
        edge_gap(0, 3 * per(), gap);
        check("ps3_period", gap, 1020);
        spi_rd(7'h7F, rd);
        check("rd_unmapped_7f", rd, 8'h00);
        spi_wr(7'h01, 8'hFF);
        spi_rd(7'h01, rd);
        check("rd_out_en_hi_absent", rd, m_read(7'h01));
        spi_rd(7'h14, rd);
        check("rd_duty_absent", rd, 8'h00);

        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < NCH; k++) begin
                case ($urandom_range(0, 3))
                    0:       rv = 8'h00;
                    1:       rv = 8'hFF;
                    default: rv = 8'($urandom_range(1, 254));
                endcase
                spi_wr(7'h10 + 7'(k), rv);
            end
            spi_wr(7'h00, 8'($urandom_range(0, 255)));
            spi_wr(7'h02, 8'($urandom_range(0, 255)));
            spi_wr(7'h04, 8'($urandom_range(0, 2)));
            rv = 8'($urandom_range(0, 4));
            spi_rd(7'(rv), rd);
            check($sformatf("rand%0d_rd_%0h", it, rv), rd, m_read(7'(rv)));
            rv = 8'h10 + 8'($urandom_range(0, NCH - 1));
            spi_rd(7'(rv), rd);
            check($sformatf("rand%0d_rd_%0h", it, rv), rd, m_read(7'(rv)));
            tick_n(per() + 10);
            check_all($sformatf("rand%0d", it));
        end

        spi_wr(7'h00, 8'hFF);
        spi_wr(7'h02, 8'h00);
        tick_n(5);
        check("pre_reset_all_high", pwm_out, {NCH{1'b1}});
        ncs = 1'b0;
        tick_n(HALF);
        for (int i = 0; i < 6; i++) spi_bit(1'b1, copi);
        rst_n = 1'b0;
        #1;
        check("midframe_rst_pwm", pwm_out, '0);
        check("midframe_rst_cipo", cipo, 1'b0);
        check("midframe_rst_oe", cipo_oe, 1'b0);
        ncs = 1'b1;
        copi = 1'b0;
        tick_n(4);
        rst_n = 1'b1;
        m_reset();
        tick_n(4);
        spi_rd(7'h04, rd);
        check("post_rst_prescale", rd, PRST);
        spi_rd(7'h00, rd);
        check("post_rst_out_en", rd, 8'h00);
        check("post_rst_pwm", pwm_out, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
